// File: rtl/upc_sequencer.sv
// Micro-program counter sequencer: INC/JMP/BCC/CALL/RET/HOLD/CLR with a
// LIFO return-address stack and a sticky overflow/underflow error flag.
module upc_sequencer #(
    parameter  int ADDR_W      = 5,
    parameter  int STACK_DEPTH = 4,
    localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [2:0]        op,
    input  logic              cond,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] upc,
    output logic [SP_W-1:0]   sp,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              err
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int MEM_N = 1 << IDX_W;

    typedef enum logic [2:0] {
        OP_INC  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BCC  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_HOLD = 3'd5,
        OP_CLR  = 3'd6,
        OP_RSV  = 3'd7
    } op_e;

    logic [ADDR_W-1:0] upc_q, upc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] upc_inc;
    logic [ADDR_W-1:0] stack_top;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              full;
    logic              empty;
    logic              push;

    // Small return-address file; read combinationally so RET completes in one cycle.
    logic [ADDR_W-1:0] stack_mem [MEM_N];

    assign upc_inc   = upc_q + ADDR_W'(1);
    assign full      = (sp_q == SP_W'(STACK_DEPTH));
    assign empty     = (sp_q == '0);
    assign wr_idx    = IDX_W'(sp_q);
    assign rd_idx    = IDX_W'(sp_q - SP_W'(1));
    assign stack_top = stack_mem[rd_idx];

    always_comb begin
        upc_d = upc_q;
        sp_d  = sp_q;
        err_d = err_q;
        push  = 1'b0;
        if (en) begin
            case (op_e'(op))
                OP_INC: upc_d = upc_inc;
                OP_JMP: upc_d = target;
                OP_BCC: upc_d = cond ? target : upc_inc;
                OP_CALL: begin
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        push  = 1'b1;
                        upc_d = target;
                        sp_d  = sp_q + SP_W'(1);
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        err_d = 1'b1;
                    end else begin
                        upc_d = stack_top;
                        sp_d  = sp_q - SP_W'(1);
                    end
                end
                OP_HOLD: upc_d = upc_q;
                OP_CLR: begin
                    // err is deliberately left alone: only reset clears it
                    upc_d = '0;
                    sp_d  = '0;
                end
                default: upc_d = upc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upc_q <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            upc_q <= upc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Stack storage carries no reset; entries are invisible until sp covers them.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            stack_mem[wr_idx] <= upc_inc;
        end
    end

    assign upc       = upc_q;
    assign sp        = sp_q;
    assign err       = err_q;
    assign stk_full  = full;
    assign stk_empty = empty;

endmodule
